// File: rtl/bit_corr_scheduler.sv
// rtl/bit_corr_scheduler.sv - round-robin serial-bit scheduler for a multi-channel correlator
// Tags each issued bit with its channel so returned scores can be matched and held off per channel.
module bit_corr_scheduler #(
    parameter int C_CHANNELS    = 4,
    parameter int C_SCORE_WIDTH = 5,
    parameter int C_THRESHOLD   = 14,
    parameter int C_HOLDOFF     = 8,
    parameter int C_TIMEOUT     = 16,
    parameter bit C_PAD_BIT     = 1'b0
) (
    input  logic                     CLK,
    input  logic                     ACLR,
    input  logic [C_CHANNELS-1:0]    REQ,
    input  logic [C_CHANNELS-1:0]    REQ_DIN,
    output logic [C_CHANNELS-1:0]    GNT,
    output logic                     CORR_ND,
    output logic                     CORR_DIN,
    input  logic                     CORR_RFD,
    input  logic [C_SCORE_WIDTH-1:0] CORR_DOUT,
    input  logic                     CORR_RDY,
    output logic                     MATCH,
    output logic [2:0]               MATCH_CH,
    output logic [C_SCORE_WIDTH-1:0] MATCH_SCORE,
    output logic                     PAD_INJ,
    output logic                     ERR
);

    localparam int CW = (C_CHANNELS > 1) ? $clog2(C_CHANNELS) : 1;
    localparam int IW = (C_TIMEOUT > 0) ? $clog2(C_TIMEOUT + 1) : 1;
    localparam int HW = (C_HOLDOFF > 0) ? $clog2(C_HOLDOFF + 1) : 1;
    localparam int FD = 8;

    logic [CW-1:0]  cur;
    logic [IW-1:0]  idle_cnt;
    logic [2:0]     fifo_mem [FD];
    logic [2:0]     wr_ptr;
    logic [2:0]     rd_ptr;
    logic [3:0]     fifo_cnt;
    logic [HW-1:0]  ho [C_CHANNELS];

    logic           req_cur;
    logic           real_issue;
    logic           pad_issue;
    logic           issue;
    logic           fifo_empty;
    logic           fifo_full;
    logic           pop_ok;
    logic           push_ok;
    logic [2:0]     tag;
    logic [CW-1:0]  tag_ch;
    logic [HW-1:0]  ho_t;
    logic           hit;

    always_comb begin
        req_cur    = REQ[cur];
        real_issue = CORR_RFD & req_cur;
        pad_issue  = CORR_RFD & ~req_cur & (idle_cnt >= IW'(C_TIMEOUT));
        issue      = real_issue | pad_issue;

        GNT      = real_issue ? (C_CHANNELS'(1) << cur) : '0;
        CORR_ND  = issue;
        CORR_DIN = real_issue ? REQ_DIN[cur] : (pad_issue & C_PAD_BIT);
        PAD_INJ  = pad_issue;

        fifo_empty = (fifo_cnt == 4'd0);
        fifo_full  = (fifo_cnt == 4'(FD));
        pop_ok     = CORR_RDY & ~fifo_empty;
        // A pop in the same cycle frees a slot, so a full FIFO can still accept
        push_ok    = issue & (~fifo_full | pop_ok);

        tag    = pop_ok ? fifo_mem[rd_ptr] : 3'd0;
        tag_ch = tag[CW-1:0];
        ho_t   = ho[tag_ch];
        hit    = CORR_RDY & (ho_t == '0) & (int'(CORR_DOUT) >= C_THRESHOLD);
    end

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= 3'(cur);
        end
    end

    always_ff @(posedge CLK or posedge ACLR) begin
        if (ACLR) begin
            cur         <= '0;
            idle_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            MATCH       <= 1'b0;
            MATCH_CH    <= '0;
            MATCH_SCORE <= '0;
            ERR         <= 1'b0;
            for (int i = 0; i < C_CHANNELS; i++) begin
                ho[i] <= '0;
            end
        end else begin
            if (issue) begin
                cur      <= (cur == CW'(C_CHANNELS - 1)) ? '0 : cur + CW'(1);
                idle_cnt <= '0;
            end else if (CORR_RFD & ~req_cur) begin
                idle_cnt <= idle_cnt + IW'(1);
            end

            if (push_ok) begin
                wr_ptr <= wr_ptr + 3'd1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 3'd1;
            end
            fifo_cnt <= fifo_cnt + 4'(push_ok) - 4'(pop_ok);

            if ((CORR_RDY & fifo_empty) | (issue & ~push_ok)) begin
                ERR <= 1'b1;
            end

            // Empty pops still score against tag 0
            MATCH <= hit;
            if (hit) begin
                MATCH_CH    <= tag;
                MATCH_SCORE <= CORR_DOUT;
                ho[tag_ch]  <= HW'(C_HOLDOFF);
            end else if (CORR_RDY && (ho_t != '0)) begin
                ho[tag_ch]  <= ho_t - HW'(1);
            end
        end
    end

endmodule

// File: tb/tb_bit_corr_scheduler.sv
// tb/tb_bit_corr_scheduler.sv - randomized and directed checks of bit_corr_scheduler against a queue model
module tb_bit_corr_scheduler;

    localparam int N    = 4;
    localparam int SW   = 5;
    localparam int TH   = 14;
    localparam int HOLD = 8;
    localparam int TO   = 16;
    localparam bit PADB = 1'b0;

    logic          CLK = 1'b0;
    logic          ACLR;
    logic [N-1:0]  REQ, REQ_DIN, GNT;
    logic          CORR_ND, CORR_DIN, CORR_RFD, CORR_RDY;
    logic [SW-1:0] CORR_DOUT, MATCH_SCORE;
    logic          MATCH, PAD_INJ, ERR;
    logic [2:0]    MATCH_CH;

    bit_corr_scheduler #(
        .C_CHANNELS(N), .C_SCORE_WIDTH(SW), .C_THRESHOLD(TH),
        .C_HOLDOFF(HOLD), .C_TIMEOUT(TO), .C_PAD_BIT(PADB)
    ) dut (
        .CLK(CLK), .ACLR(ACLR), .REQ(REQ), .REQ_DIN(REQ_DIN), .GNT(GNT),
        .CORR_ND(CORR_ND), .CORR_DIN(CORR_DIN), .CORR_RFD(CORR_RFD),
        .CORR_DOUT(CORR_DOUT), .CORR_RDY(CORR_RDY), .MATCH(MATCH),
        .MATCH_CH(MATCH_CH), .MATCH_SCORE(MATCH_SCORE), .PAD_INJ(PAD_INJ), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: channel pointer, idle count, tag queue, per-channel holdoff
    int m_cur, m_idle, m_mch, m_msc;
    int tagq[$];
    int m_ho[N];
    bit m_match, m_err;

    logic [N-1:0]  obs_gnt;
    logic          obs_nd, obs_din, obs_pad, obs_match, obs_err;
    logic [2:0]    obs_mch;
    logic [SW-1:0] obs_msc;

    task automatic model_reset();
        m_cur = 0; m_idle = 0; m_mch = 0; m_msc = 0;
        m_match = 0; m_err = 0;
        tagq.delete();
        for (int i = 0; i < N; i++) m_ho[i] = 0;
    endtask

    // Inputs are already driven; check, advance the model, and step one clock.
    task automatic cycle();
        bit real_i, pad_i;
        int t;
        #1;
        real_i = CORR_RFD && REQ[m_cur];
        pad_i  = CORR_RFD && !real_i && (m_idle >= TO);
        obs_gnt = GNT; obs_nd = CORR_ND; obs_din = CORR_DIN; obs_pad = PAD_INJ;
        obs_match = MATCH; obs_err = ERR; obs_mch = MATCH_CH; obs_msc = MATCH_SCORE;
        check("gnt", 32'(GNT), real_i ? 32'(1 << m_cur) : 32'd0);
        check("nd", 32'(CORR_ND), 32'(real_i || pad_i));
        check("din", 32'(CORR_DIN), real_i ? 32'(REQ_DIN[m_cur]) : (pad_i ? 32'(PADB) : 32'd0));
        check("pad", 32'(PAD_INJ), 32'(pad_i));
        check("match", 32'(MATCH), 32'(m_match));
        check("match_ch", 32'(MATCH_CH), 32'(m_mch));
        check("match_score", 32'(MATCH_SCORE), 32'(m_msc));
        check("err", 32'(ERR), 32'(m_err));

        m_match = 0;
        if (CORR_RDY) begin
            if (tagq.size() == 0) begin
                m_err = 1;
                t = 0;
            end else begin
                t = tagq.pop_front();
            end
            if (m_ho[t] == 0 && int'(CORR_DOUT) >= TH) begin
                m_match = 1; m_mch = t; m_msc = int'(CORR_DOUT); m_ho[t] = HOLD;
            end else if (m_ho[t] > 0) begin
                m_ho[t]--;
            end
        end
        if (real_i || pad_i) begin
            if (tagq.size() < 8) tagq.push_back(m_cur);
            else m_err = 1;
            m_idle = 0;
            m_cur = (m_cur + 1) % N;
        end else if (CORR_RFD && !REQ[m_cur]) begin
            m_idle++;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] req, input logic rfd, input logic rdy, input logic [SW-1:0] sc);
        REQ = req; REQ_DIN = N'($urandom); CORR_RFD = rfd; CORR_RDY = rdy; CORR_DOUT = sc;
    endtask

    task automatic do_reset();
        ACLR = 1'b1;
        drive('1, 1'b1, 1'b0, '0);
        #1;
        check("rst_err", 32'(ERR), 32'd0);
        check("rst_match", 32'(MATCH), 32'd0);
        check("rst_match_ch", 32'(MATCH_CH), 32'd0);
        check("rst_match_score", 32'(MATCH_SCORE), 32'd0);
        check("rst_pad", 32'(PAD_INJ), 32'd0);
        check("rst_gnt", 32'(GNT), 32'd1);
        check("rst_nd", 32'(CORR_ND), 32'd1);
        model_reset();
        @(posedge CLK);
        #1;
        ACLR = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt, ridx, pend;
        logic [9:0] hits;
        logic [SW-1:0] sc [9];

        ACLR = 1'b1;
        drive('0, 1'b0, 1'b0, '0);
        @(posedge CLK);
        #1;
        do_reset();

        // Round robin with every requester active
        for (int i = 0; i < 5; i++) begin
            drive('1, 1'b1, 1'b0, '0);
            cycle();
            check("rr_gnt", 32'(obs_gnt), 32'(4'b0001 << (i % 4)));
            check("rr_nd", 32'(obs_nd), 32'd1);
        end

        // Stall on channel 1 until a pad bit is injected
        do_reset();
        drive(4'b1101, 1'b1, 1'b0, '0);
        cycle();
        check("stall_first_gnt", 32'(obs_gnt), 32'h1);
        cnt = 0;
        for (int i = 0; i < TO; i++) begin
            drive(4'b1101, 1'b1, 1'b0, '0);
            cycle();
            if (!obs_nd && !obs_pad) cnt++;
        end
        check("stall_idle_cycles", 32'(cnt), 32'(TO));
        drive(4'b1101, 1'b1, 1'b0, '0);
        REQ_DIN = '1;
        cycle();
        check("pad_nd", 32'(obs_nd), 32'd1);
        check("pad_din", 32'(obs_din), 32'(PADB));
        check("pad_inj", 32'(obs_pad), 32'd1);
        check("pad_gnt", 32'(obs_gnt), 32'd0);
        drive(4'b1101, 1'b1, 1'b0, '0);
        cycle();
        check("after_pad_gnt", 32'(obs_gnt), 32'h4);

        // Threshold: tag 2 scores 13 (no match), later tag 2 scores 14 (match)
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive('1, 1'b1, 1'b0, '0);
            cycle();
        end
        sc = '{5'd0, 5'd0, 5'd13, 5'd0, 5'd0, 5'd0, 5'd14, 5'd0, 5'd0};
        for (int i = 0; i < 9; i++) begin
            drive('0, 1'b0, (i < 8), sc[i]);
            cycle();
            if (i == 3) check("thr13_nomatch", 32'(obs_match), 32'd0);
            if (i == 7) begin
                check("thr14_match", 32'(obs_match), 32'd1);
                check("thr14_ch", 32'(obs_mch), 32'd2);
                check("thr14_score", 32'(obs_msc), 32'd14);
            end
        end

        // Holdoff: ten consecutive channel-2 results of 15
        do_reset();
        hits = '0; ridx = 0; pend = -1;
        for (int i = 0; i < 80 && (ridx < 10 || pend >= 0); i++) begin
            bit rdy, is2;
            rdy = (tagq.size() > 0);
            is2 = rdy && (tagq[0] == 2);
            drive('1, 1'b1, rdy, is2 ? 5'd15 : 5'd0);
            cycle();
            if (pend >= 0) begin
                if (obs_match && obs_mch == 3'd2) hits[pend] = 1'b1;
                pend = -1;
            end
            if (is2 && ridx < 10) begin
                pend = ridx;
                ridx++;
            end
        end
        check("holdoff_hits", 32'(hits), 32'(10'b10_0000_0001));

        // Backpressure holds the pointer
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive('1, 1'b1, 1'b0, '0);
            cycle();
        end
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            drive('1, 1'b0, 1'b0, '0);
            cycle();
            if (obs_nd || obs_pad || obs_gnt != '0) cnt++;
        end
        check("bp_no_issue", 32'(cnt), 32'd0);
        drive('1, 1'b1, 1'b0, '0);
        cycle();
        check("bp_gnt", 32'(obs_gnt), 32'h4);

        // Reset discards in-flight tags; empty pop flags ERR; reset clears it
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive('1, 1'b1, 1'b0, '0);
            cycle();
        end
        do_reset();
        drive('0, 1'b1, 1'b1, 5'd0);
        cycle();
        drive('0, 1'b1, 1'b0, 5'd0);
        cycle();
        check("empty_pop_err", 32'(obs_err), 32'd1);
        do_reset();
        drive('1, 1'b1, 1'b0, '0);
        cycle();
        check("post_rst_gnt", 32'(obs_gnt), 32'h1);
        check("post_rst_err", 32'(obs_err), 32'd0);

        // Random traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bit rdy;
            rdy = ((tagq.size() > 0) && ($urandom_range(0, 1) == 1)) || ($urandom_range(0, 99) == 0);
            drive(N'($urandom), ($urandom_range(0, 3) != 0), rdy, SW'($urandom_range(8, 31)));
            cycle();
        end

        // Sparse requests so pad bits appear
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] r;
            for (int c = 0; c < N; c++) r[c] = ($urandom_range(0, 24) == 0);
            drive(r, ($urandom_range(0, 4) != 0), (tagq.size() > 0) && ($urandom_range(0, 2) == 0),
                  SW'($urandom));
            cycle();
        end

        // Overflow the tag FIFO
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive('1, 1'b1, 1'b0, '0);
            cycle();
        end
        check("overflow_err", 32'(obs_err), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
